// File: rtl/reg_file_sb.sv
// Register file with two write ports, two bypassed synchronous read ports and a
// pending scoreboard that stalls reads of registers reserved but not yet written.
module reg_file_sb #(
  parameter int WIDTH    = 9,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic signed [WIDTH-1:0]  wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic signed [WIDTH-1:0]  wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd0_addr,
  input  logic [ADDR_W-1:0]        rd1_addr,
  output logic                     stall,
  output logic                     rd_valid,
  output logic signed [WIDTH-1:0]  rd0_data,
  output logic signed [WIDTH-1:0]  rd1_data,
  output logic [2**ADDR_W-1:0]     pending
);

  localparam int DEPTH = 2**ADDR_W;

  logic signed [WIDTH-1:0] regs      [DEPTH];
  logic signed [WIDTH-1:0] regs_next [DEPTH];
  logic [DEPTH-1:0]        wr_mask;
  logic [DEPTH-1:0]        rsv_mask;
  logic [DEPTH-1:0]        pending_next;
  logic                    wr0_eff;
  logic                    wr1_eff;
  logic                    p0;
  logic                    p1;
  logic                    accept;

  // wr1 (load path) wins a same-address collision; reservations override a
  // same-cycle write because they belong to a newer instruction.
  always_comb begin
    wr1_eff  = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));
    wr0_eff  = wr0_en && !(wr1_en && (wr1_addr == wr0_addr))
                      && !((ZERO_REG != 0) && (wr0_addr == '0));
    wr_mask  = '0;
    rsv_mask = '0;
    if (wr0_en) wr_mask[wr0_addr] = 1'b1;
    if (wr1_en) wr_mask[wr1_addr] = 1'b1;
    if (rsv_en) rsv_mask[rsv_addr] = 1'b1;
    pending_next = (pending & ~wr_mask) | rsv_mask;
    if (ZERO_REG != 0) pending_next[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      regs_next[i] = regs[i];
      if (wr0_eff && (wr0_addr == ADDR_W'(i))) regs_next[i] = wr0_data;
      if (wr1_eff && (wr1_addr == ADDR_W'(i))) regs_next[i] = wr1_data;
    end
  end

  // A write landing this cycle cancels the stall since its data is bypassed.
  always_comb begin
    p0     = pending[rd0_addr] && !wr_mask[rd0_addr];
    p1     = pending[rd1_addr] && !wr_mask[rd1_addr];
    stall  = rd_en && (p0 || p1);
    accept = rd_en && !stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending  <= '0;
      rd_valid <= 1'b0;
      rd0_data <= '0;
      rd1_data <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= regs_next[i];
      pending  <= pending_next;
      rd_valid <= accept;
      if (accept) begin
        rd0_data <= regs_next[rd0_addr];
        rd1_data <= regs_next[rd1_addr];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed vector table, randomized run
// against a reference model, and a ZERO_REG=1 / WIDTH=16 / ADDR_W=3 instance.
module tb_reg_file_sb;

  typedef struct {
    logic              w0e;
    logic [1:0]        w0a;
    logic signed [8:0] w0d;
    logic              w1e;
    logic [1:0]        w1a;
    logic signed [8:0] w1d;
    logic              re;
    logic [1:0]        ra;
    logic              rde;
    logic [1:0]        r0a;
    logic [1:0]        r1a;
    logic              xs;
    logic              xv;
    logic signed [8:0] x0;
    logic signed [8:0] x1;
    logic [3:0]        xp;
  } vec_t;

  logic clk;
  logic rst;

  logic              a_wr0_en, a_wr1_en, a_rsv_en, a_rd_en;
  logic [1:0]        a_wr0_addr, a_wr1_addr, a_rsv_addr, a_rd0_addr, a_rd1_addr;
  logic signed [8:0] a_wr0_data, a_wr1_data, a_rd0_data, a_rd1_data;
  logic              a_stall, a_rd_valid;
  logic [3:0]        a_pending;

  logic               b_wr0_en, b_wr1_en, b_rsv_en, b_rd_en;
  logic [2:0]         b_wr0_addr, b_wr1_addr, b_rsv_addr, b_rd0_addr, b_rd1_addr;
  logic signed [15:0] b_wr0_data, b_wr1_data, b_rd0_data, b_rd1_data;
  logic               b_stall, b_rd_valid;
  logic [7:0]         b_pending;

  int checks = 0;
  int errors = 0;

  int   mregs [4];
  bit   mpend [4];
  int   mrd0, mrd1;
  vec_t vecs  [18];

  reg_file_sb #(.WIDTH(9), .ADDR_W(2), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst(rst),
    .wr0_en(a_wr0_en), .wr0_addr(a_wr0_addr), .wr0_data(a_wr0_data),
    .wr1_en(a_wr1_en), .wr1_addr(a_wr1_addr), .wr1_data(a_wr1_data),
    .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr),
    .rd_en(a_rd_en), .rd0_addr(a_rd0_addr), .rd1_addr(a_rd1_addr),
    .stall(a_stall), .rd_valid(a_rd_valid),
    .rd0_data(a_rd0_data), .rd1_data(a_rd1_data), .pending(a_pending)
  );

  reg_file_sb #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst),
    .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
    .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
    .rd_en(b_rd_en), .rd0_addr(b_rd0_addr), .rd1_addr(b_rd1_addr),
    .stall(b_stall), .rd_valid(b_rd_valid),
    .rd0_data(b_rd0_data), .rd1_data(b_rd1_data), .pending(b_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input int w0e, input int w0a, input int w0d,
                              input int w1e, input int w1a, input int w1d,
                              input int re, input int ra,
                              input int rde, input int r0a, input int r1a,
                              input int xs, input int xv, input int x0,
                              input int x1, input int xp);
    vec_t v;
    v.w0e = 1'(w0e); v.w0a = 2'(w0a); v.w0d = 9'(w0d);
    v.w1e = 1'(w1e); v.w1a = 2'(w1a); v.w1d = 9'(w1d);
    v.re  = 1'(re);  v.ra  = 2'(ra);
    v.rde = 1'(rde); v.r0a = 2'(r0a); v.r1a = 2'(r1a);
    v.xs  = 1'(xs);  v.xv  = 1'(xv);  v.x0 = 9'(x0); v.x1 = 9'(x1);
    v.xp  = 4'(xp);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    a_wr0_en = v.w0e; a_wr0_addr = v.w0a; a_wr0_data = v.w0d;
    a_wr1_en = v.w1e; a_wr1_addr = v.w1a; a_wr1_data = v.w1d;
    a_rsv_en = v.re;  a_rsv_addr = v.ra;
    a_rd_en  = v.rde; a_rd0_addr = v.r0a; a_rd1_addr = v.r1a;
  endtask

  // Called just after a rising edge: drive, check stall mid-cycle, then check
  // the registered outputs 1 time unit after the next edge.
  task automatic runCycleA(input vec_t v, input string tag);
    applyStimulus(v);
    #1;
    checkOutput({tag, "_stall"}, int'(a_stall), int'(v.xs));
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid"}, int'(a_rd_valid), int'(v.xv));
    checkOutput({tag, "_rd0"}, int'(a_rd0_data), int'(v.x0));
    checkOutput({tag, "_rd1"}, int'(a_rd1_data), int'(v.x1));
    checkOutput({tag, "_pending"}, int'(a_pending), int'(v.xp));
  endtask

  task automatic resetModel();
    for (int i = 0; i < 4; i++) begin
      mregs[i] = 0;
      mpend[i] = 1'b0;
    end
    mrd0 = 0;
    mrd1 = 0;
  endtask

  // Reference behaviour: stall is decided on the pre-edge scoreboard, then the
  // edge applies writes, scoreboard updates and the bypassed read.
  function automatic vec_t modelStep(input vec_t vin);
    vec_t v;
    bit   hit0, hit1, s, valid;
    v    = vin;
    hit0 = (v.w0e && v.w0a == v.r0a) || (v.w1e && v.w1a == v.r0a);
    hit1 = (v.w0e && v.w0a == v.r1a) || (v.w1e && v.w1a == v.r1a);
    s    = v.rde && ((mpend[v.r0a] && !hit0) || (mpend[v.r1a] && !hit1));
    if (v.w0e && !(v.w1e && v.w1a == v.w0a)) mregs[v.w0a] = int'(v.w0d);
    if (v.w1e) mregs[v.w1a] = int'(v.w1d);
    if (v.w0e) mpend[v.w0a] = 1'b0;
    if (v.w1e) mpend[v.w1a] = 1'b0;
    if (v.re)  mpend[v.ra]  = 1'b1;
    valid = v.rde && !s;
    if (valid) begin
      mrd0 = mregs[v.r0a];
      mrd1 = mregs[v.r1a];
    end
    v.xs = s;
    v.xv = valid;
    v.x0 = 9'(mrd0);
    v.x1 = 9'(mrd1);
    v.xp = {mpend[3], mpend[2], mpend[1], mpend[0]};
    return v;
  endfunction

  task automatic idleB();
    b_wr0_en = 1'b0; b_wr0_addr = '0; b_wr0_data = '0;
    b_wr1_en = 1'b0; b_wr1_addr = '0; b_wr1_data = '0;
    b_rsv_en = 1'b0; b_rsv_addr = '0;
    b_rd_en  = 1'b0; b_rd0_addr = '0; b_rd1_addr = '0;
  endtask

  initial begin
    vec_t v;

    //            w0e w0a w0d   w1e w1a w1d   re ra  rde r0 r1  xs xv x0   x1    xp
    vecs[0]  = mk(1, 1, 100,    0, 0, 0,      0, 0,  0, 0, 0,   0, 0, 0,   0,    0);
    vecs[1]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  1, 1, 2,   0, 1, 100, 0,    0);
    vecs[2]  = mk(1, 2, -5,     1, 2, 77,     0, 0,  0, 0, 0,   0, 0, 100, 0,    0);
    vecs[3]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  1, 2, 1,   0, 1, 77,  100,  0);
    vecs[4]  = mk(1, 1, 3,      1, 3, -256,   0, 0,  1, 1, 3,   0, 1, 3,   -256, 0);
    vecs[5]  = mk(1, 3, -1,     0, 0, 0,      0, 0,  1, 3, 0,   0, 1, -1,  0,    0);
    vecs[6]  = mk(0, 0, 0,      0, 0, 0,      1, 2,  1, 2, 2,   0, 1, 77,  77,   4);
    vecs[7]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  1, 2, 0,   1, 0, 77,  77,   4);
    vecs[8]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  1, 2, 0,   1, 0, 77,  77,   4);
    vecs[9]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  1, 2, 0,   1, 0, 77,  77,   4);
    vecs[10] = mk(0, 0, 0,      1, 2, 42,     0, 0,  1, 2, 0,   0, 1, 42,  0,    0);
    vecs[11] = mk(0, 0, 0,      0, 0, 0,      0, 0,  0, 0, 0,   0, 0, 42,  0,    0);
    vecs[12] = mk(1, 1, 5,      0, 0, 0,      1, 1,  1, 1, 1,   0, 1, 5,   5,    2);
    vecs[13] = mk(0, 0, 0,      0, 0, 0,      0, 0,  1, 1, 3,   1, 0, 5,   5,    2);
    vecs[14] = mk(0, 0, 0,      0, 0, 0,      1, 1,  1, 0, 0,   0, 1, 0,   0,    2);
    vecs[15] = mk(1, 1, -7,     1, 1, 8,      0, 0,  1, 1, 1,   0, 1, 8,   8,    0);
    vecs[16] = mk(0, 0, 0,      0, 0, 0,      1, 3,  1, 0, 3,   0, 1, 0,   -1,   8);
    vecs[17] = mk(1, 3, 2,      0, 0, 0,      0, 0,  1, 1, 3,   0, 1, 8,   2,    0);

    rst = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    idleB();
    #3;
    checkOutput("reset_valid", int'(a_rd_valid), 0);
    checkOutput("reset_rd0", int'(a_rd0_data), 0);
    checkOutput("reset_rd1", int'(a_rd1_data), 0);
    checkOutput("reset_pending", int'(a_pending), 0);
    checkOutput("reset_stall", int'(a_stall), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 18; i++) runCycleA(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] ZERO_REG instance");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    b_wr0_en = 1'b1; b_wr0_addr = 3'd0; b_wr0_data = 16'sh1234;
    b_rsv_en = 1'b1; b_rsv_addr = 3'd0;
    b_rd_en  = 1'b1; b_rd0_addr = 3'd0; b_rd1_addr = 3'd0;
    #1;
    checkOutput("zr_r0_stall", int'(b_stall), 0);
    @(posedge clk);
    #1;
    checkOutput("zr_r0_pending", int'(b_pending), 0);
    checkOutput("zr_r0_valid", int'(b_rd_valid), 1);
    checkOutput("zr_r0_data", int'(b_rd0_data), 0);
    idleB();
    b_wr1_en = 1'b1; b_wr1_addr = 3'd7; b_wr1_data = -16'sd32768;
    b_rd_en  = 1'b1; b_rd0_addr = 3'd7; b_rd1_addr = 3'd0;
    #1;
    checkOutput("zr_r7_stall", int'(b_stall), 0);
    @(posedge clk);
    #1;
    checkOutput("zr_r7_valid", int'(b_rd_valid), 1);
    checkOutput("zr_r7_rd0", int'(b_rd0_data), -32768);
    checkOutput("zr_r7_rd1", int'(b_rd1_data), 0);
    idleB();
    b_rsv_en = 1'b1; b_rsv_addr = 3'd5;
    @(posedge clk);
    #1;
    checkOutput("zr_r5_pending", int'(b_pending), 32);
    idleB();
    b_rd_en = 1'b1; b_rd0_addr = 3'd0; b_rd1_addr = 3'd5;
    #1;
    checkOutput("zr_r5_stall", int'(b_stall), 1);
    b_rd1_addr = 3'd0;
    #1;
    checkOutput("zr_r0_nostall", int'(b_stall), 0);
    @(posedge clk);
    #1;
    idleB();

    $display("[TB] reset mid-operation");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput("mid_valid_before", int'(a_rd_valid), 1);
    checkOutput("mid_pending_before", int'(a_pending), 4);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_valid", int'(a_rd_valid), 0);
    checkOutput("mid_rd0", int'(a_rd0_data), 0);
    checkOutput("mid_rd1", int'(a_rd1_data), 0);
    checkOutput("mid_pending", int'(a_pending), 0);
    checkOutput("mid_stall", int'(a_stall), 0);
    checkOutput("mid_pending_b", int'(b_pending), 0);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    @(posedge clk);
    #1;

    $display("[TB] randomized run against reference model");
    for (int n = 0; n < 400; n++) begin
      v.w0e = ($urandom_range(0, 1) == 1);
      v.w0a = 2'($urandom_range(0, 3));
      v.w0d = 9'($urandom_range(0, 511));
      v.w1e = ($urandom_range(0, 2) == 0);
      v.w1a = 2'($urandom_range(0, 3));
      v.w1d = 9'($urandom_range(0, 511));
      v.re  = ($urandom_range(0, 3) == 0);
      v.ra  = 2'($urandom_range(0, 3));
      v.rde = ($urandom_range(0, 9) < 7);
      v.r0a = 2'($urandom_range(0, 3));
      v.r1a = 2'($urandom_range(0, 3));
      v = modelStep(v);
      runCycleA(v, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file for the processor datapath: signed WIDTH-bit registers, two write ports, two synchronous read ports with same-edge write bypass, and a per-register pending scoreboard. A read of a register that is reserved but not yet written is stalled. It replaces the fixed four-entry, single-write-port file. The ALU result and the load path write through separate ports, and the issue stage reserves destination registers.

## Interface
- WIDTH, 9, data width in bits; data is signed two's complement.
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 0, when 1, register 0 always reads 0 and ignores writes and reservations.

Ports:
- clk  in  1  clock, rising-edge active
- rst  in  1  reset, asynchronous, active-high
- wr0_en  in  1  write port 0 enable (ALU)
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  WIDTH  write port 0 data, signed
- wr1_en  in  1  write port 1 enable (load path, higher priority)
- wr1_addr  in  ADDR_W  write port 1 address
- wr1_data  in  WIDTH  write port 1 data, signed
- rsv_en  in  1  reserve request: mark rsv_addr pending
- rsv_addr  in  ADDR_W  register to reserve
- rd_en  in  1  read request for both read addresses
- rd0_addr, rd1_addr  in  ADDR_W  read addresses
- stall  out  1  combinational: read request refused this cycle
- rd_valid  out  1  registered: rd0_data/rd1_data updated by the read accepted last cycle
- rd0_data, rd1_data  out  WIDTH  registered read data, signed
- pending  out  DEPTH  registered scoreboard, bit i = register i reserved and unwritten

## Operation
- **Write.** On each rising clk, an enabled port writes its register.
  - Both ports enabled to the same address: wr1 wins; wr0 is dropped.
  - Different addresses: both are written.
- **Scoreboard.**
  - A write by either port clears pending[addr].
  - rsv_en sets pending[rsv_addr].
  - rsv_en and a write to the same address in the same cycle: pending ends set, because the reservation belongs to a newer instruction.
  - Re-reserving a register that is already pending leaves it set.
- **Read stall.** stall = rd_en AND (p0 OR p1).
  - p0 = pending[rd0_addr] AND NOT (a write to rd0_addr this cycle); p1 is the same for rd1_addr.
  - A same-cycle rsv_en does not affect stall; the read is ordered before the reserving instruction.
- **Read accept.** A read is accepted when rd_en=1 and stall=0.
  - Outputs are register contents as updated by this edge's writes (write bypass, wr1 priority applied).
  - rd_valid=1 for exactly the next cycle.
  - When no read is accepted: rd_valid=0, and rd0_data/rd1_data hold their previous values.
- **ZERO_REG=1.**
  - Writes to address 0 are ignored.
  - pending[0] is constant 0 and reservations of 0 are ignored.
  - Reads of 0 return 0.
- **Out-of-range addresses:** none; DEPTH is always 2**ADDR_W.

## Timing
- **Reset.** While rst is high, the following hold regardless of clk:
  - all registers = 0, pending = 0;
  - rd_valid = 0, rd0_data = rd1_data = 0.
  - stall stays combinational; it is 0 during reset because pending = 0.
- **Reset mid-operation.** All reservations are lost. A read accepted on the edge before rst rises has its rd_valid forced to 0.
- **Latency.** Read latency is 1 cycle: address and rd_en are sampled at edge N, and data is valid after edge N with rd_valid high until edge N+1.
- **Write to read.** A write at edge N is visible to a read accepted at the same edge N (bypass). No separate forwarding is needed upstream.
- **Reserve to stall.**
  - rsv at edge N: a read of that register is stalled from cycle N+1.
  - Write at edge M: the read is unstalled in cycle M itself, because the write cancels its own stall and the data is bypassed.
- **Stall path.** stall depends only on rd_en, the addresses, the write enables/addresses and pending. It does not depend on data.
- **Throughput.** One read pair, two writes and one reservation per cycle.

## Test plan
- **Reset and basic write/read.**
  - Stimulus: assert rst mid-cycle, then release; write r1=9'sd100 via wr0; read rd0=r1, rd1=r2 the next cycle.
  - Required: all outputs 0 and pending=0 immediately on rst; the read returns 100 and 0 with rd_valid=1 for one cycle.
- **Dual-write collision.**
  - Stimulus: wr0 r2=-5 and wr1 r2=77 on the same edge, then read r2.
  - Required: read returns 77. Separately, wr0 r1=3 with wr1 r3=-256 writes both.
- **Bypass.**
  - Stimulus: write r3=-1 and read r3 on the same edge.
  - Required: rd0_data=-1 (9'h1FF) after that edge; the old value never appears.
- **Scoreboard stall.**
  - Stimulus: reserve r2, then hold rd_en reading r2 for 3 cycles, then wr1 r2=42.
  - Required: pending[2]=1 and stall=1 for 3 cycles with rd_valid=0; in the write cycle stall=0 and the next cycle returns 42 with pending[2]=0.
- **Reserve/write race.**
  - Stimulus: rsv r1 and wr0 r1 on the same edge.
  - Required: pending[1]=1 afterward. Also, a read of r1 issued in the reservation cycle itself is not stalled.
- **ZERO_REG=1, WIDTH=16, ADDR_W=3.**
  - Stimulus: write r0=16'sh1234, reserve r0, read r0; write r7=-32768 and read r7.
  - Required: r0 reads 0 with pending[0]=0 and no stall; r7 reads -32768.
